// File: rtl/cl_ddr_arb_pkg.sv
// Shared types and constants for the DDR-C write-channel arbiter.
package cl_ddr_arb_pkg;

    localparam int ID_W_DEF   = 16;
    localparam int DATA_W_DEF = 512;

    // Requester index, also carried in the MSB of the DDR-side AXI ID
    localparam int REQ_DMA = 0;
    localparam int REQ_DLA = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/cl_rr_arb2.sv
// Two-way round-robin grant; the pointer is owned by the parent.
module cl_rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt
);

    // On contention ptr picks the winner, otherwise the lone requester wins
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
            else              gnt = req;
        end
    end

endmodule

// File: rtl/cl_ddr_wr_arb.sv
// Two-requester AXI4 write arbiter in front of the DDR-C write channels.
// Whole AW+W bursts are serialised, the AW ID is tagged with the requester
// index in its MSB, and B responses are steered back by that tag.
module cl_ddr_wr_arb
    import cl_ddr_arb_pkg::*;
#(
    parameter int ID_W    = ID_W_DEF,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LEN_W   = 8,
    parameter int MAX_OUT = 16
) (
    input  logic                  clk,
    input  logic                  pipe_rst_n,

    // requester 0 (PCIS DMA)
    input  logic                  s0_awvalid,
    output logic                  s0_awready,
    input  logic [ID_W-2:0]       s0_awid,
    input  logic [ADDR_W-1:0]     s0_awaddr,
    input  logic [LEN_W-1:0]      s0_awlen,
    input  logic [2:0]            s0_awsize,
    input  logic                  s0_wvalid,
    output logic                  s0_wready,
    input  logic [DATA_W-1:0]     s0_wdata,
    input  logic [DATA_W/8-1:0]   s0_wstrb,
    input  logic                  s0_wlast,
    output logic                  s0_bvalid,
    input  logic                  s0_bready,
    output logic [ID_W-2:0]       s0_bid,
    output logic [1:0]            s0_bresp,

    // requester 1 (NVDLA DBB)
    input  logic                  s1_awvalid,
    output logic                  s1_awready,
    input  logic [ID_W-2:0]       s1_awid,
    input  logic [ADDR_W-1:0]     s1_awaddr,
    input  logic [LEN_W-1:0]      s1_awlen,
    input  logic [2:0]            s1_awsize,
    input  logic                  s1_wvalid,
    output logic                  s1_wready,
    input  logic [DATA_W-1:0]     s1_wdata,
    input  logic [DATA_W/8-1:0]   s1_wstrb,
    input  logic                  s1_wlast,
    output logic                  s1_bvalid,
    input  logic                  s1_bready,
    output logic [ID_W-2:0]       s1_bid,
    output logic [1:0]            s1_bresp,

    // DDR side
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ID_W-1:0]       m_awid,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [LEN_W-1:0]      m_awlen,
    output logic [2:0]            m_awsize,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [ID_W-1:0]       m_bid,
    input  logic [1:0]            m_bresp,

    output logic [7:0]            outstanding
);

    localparam logic [7:0] MAX_OUT_C = 8'(MAX_OUT);

    arb_state_e          state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic [7:0]          out_q, out_d;
    logic [ID_W-1:0]     awid_q, awid_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [LEN_W-1:0]    awlen_q, awlen_d;
    logic [2:0]          awsize_q, awsize_d;

    logic [1:0]          req;
    logic [1:0]          gnt_oh;
    logic                arb_en;
    logic                gnt_idx;
    logic                s_aw_hs;
    logic                m_aw_hs;
    logic                in_data;
    logic                w_done;
    logic                b_sel;
    logic                b_hs;

    // ---------------------------------------------------------------
    // Grant: only in IDLE and only while a credit is left
    // ---------------------------------------------------------------
    assign req    = {s1_awvalid, s0_awvalid};
    assign arb_en = (state_q == ST_IDLE) && (out_q < MAX_OUT_C);

    cl_rr_arb2 u_rr_arb (
        .req (req),
        .ptr (rr_ptr_q),
        .en  (arb_en),
        .gnt (gnt_oh)
    );

    assign gnt_idx    = gnt_oh[REQ_DLA];
    assign s0_awready = gnt_oh[REQ_DMA];
    assign s1_awready = gnt_oh[REQ_DLA];
    assign s_aw_hs    = |gnt_oh;

    // ---------------------------------------------------------------
    // AW: registered payload, presented during ADDR
    // ---------------------------------------------------------------
    assign m_awvalid = (state_q == ST_ADDR);
    assign m_aw_hs   = m_awvalid && m_awready;
    assign m_awid    = awid_q;
    assign m_awaddr  = awaddr_q;
    assign m_awlen   = awlen_q;
    assign m_awsize  = awsize_q;

    // ---------------------------------------------------------------
    // W: straight-through mux from the granted requester during DATA
    // ---------------------------------------------------------------
    assign in_data   = (state_q == ST_DATA);
    assign m_wvalid  = in_data && (gnt_q ? s1_wvalid : s0_wvalid);
    assign m_wdata   = gnt_q ? s1_wdata : s0_wdata;
    assign m_wstrb   = gnt_q ? s1_wstrb : s0_wstrb;
    assign m_wlast   = gnt_q ? s1_wlast : s0_wlast;
    assign s0_wready = in_data && !gnt_q && m_wready;
    assign s1_wready = in_data &&  gnt_q && m_wready;
    assign w_done    = m_wvalid && m_wready && m_wlast;

    // ---------------------------------------------------------------
    // B: routed by the requester tag in the ID MSB
    // ---------------------------------------------------------------
    assign b_sel     = m_bid[ID_W-1];
    assign s0_bvalid = m_bvalid && !b_sel;
    assign s1_bvalid = m_bvalid &&  b_sel;
    assign s0_bid    = m_bid[ID_W-2:0];
    assign s1_bid    = m_bid[ID_W-2:0];
    assign s0_bresp  = m_bresp;
    assign s1_bresp  = m_bresp;
    assign m_bready  = b_sel ? s1_bready : s0_bready;
    assign b_hs      = m_bvalid && m_bready;

    assign outstanding = out_q;

    // Arbitration FSM, AW capture and round-robin pointer update
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        awid_d   = awid_q;
        awaddr_d = awaddr_q;
        awlen_d  = awlen_q;
        awsize_d = awsize_q;
        case (state_q)
            ST_IDLE: begin
                if (s_aw_hs) begin
                    state_d  = ST_ADDR;
                    gnt_d    = gnt_idx;
                    awid_d   = {gnt_idx, (gnt_idx ? s1_awid : s0_awid)};
                    awaddr_d = gnt_idx ? s1_awaddr : s0_awaddr;
                    awlen_d  = gnt_idx ? s1_awlen  : s0_awlen;
                    awsize_d = gnt_idx ? s1_awsize : s0_awsize;
                end
            end
            ST_ADDR: begin
                if (m_awready) state_d = ST_DATA;
            end
            ST_DATA: begin
                // wlast alone closes the burst; the loser of this round goes first next time
                if (w_done) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = ~gnt_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outstanding-burst count; simultaneous AW and B cancel, and it never wraps below zero
    always_comb begin
        out_d = out_q;
        if (m_aw_hs && !b_hs)
            out_d = out_q + 8'd1;
        else if (b_hs && !m_aw_hs && (out_q != 8'd0))
            out_d = out_q - 8'd1;
    end

    // State registers
    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 1'b0;
            rr_ptr_q <= 1'b0;
            out_q    <= 8'd0;
            awid_q   <= '0;
            awaddr_q <= '0;
            awlen_q  <= '0;
            awsize_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            out_q    <= out_d;
            awid_q   <= awid_d;
            awaddr_q <= awaddr_d;
            awlen_q  <= awlen_d;
            awsize_q <= awsize_d;
        end
    end

    // A B response with nothing in flight means the DDR side lost track of a burst
    a_b_underflow: assert property (@(posedge clk) disable iff (!pipe_rst_n)
        b_hs |-> (out_q != 8'd0))
        else $error("cl_ddr_wr_arb: B handshake with no outstanding bursts");

endmodule

// File: tb/tb_cl_ddr_wr_arb.sv
// Randomised bench for cl_ddr_wr_arb with a transaction-level reference model.
module tb_cl_ddr_wr_arb;

    localparam int ID_W = 8, ADDR_W = 32, DATA_W = 64, LEN_W = 8, MAX_OUT = 2;
    localparam int STRB_W = DATA_W/8;

    typedef struct {
        logic [ID_W-2:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [2:0]        size;
    } aw_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } beat_t;

    logic clk = 1'b0;
    logic pipe_rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              s_awvalid[2], s_awready[2];
    logic [ID_W-2:0]   s_awid[2];
    logic [ADDR_W-1:0] s_awaddr[2];
    logic [LEN_W-1:0]  s_awlen[2];
    logic [2:0]        s_awsize[2];
    logic              s_wvalid[2], s_wready[2], s_wlast[2];
    logic [DATA_W-1:0] s_wdata[2];
    logic [STRB_W-1:0] s_wstrb[2];
    logic              s_bvalid[2], s_bready[2];
    logic [ID_W-2:0]   s_bid[2];
    logic [1:0]        s_bresp[2];

    logic              m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
    logic              m_bvalid, m_bready;
    logic [ID_W-1:0]   m_awid, m_bid;
    logic [ADDR_W-1:0] m_awaddr;
    logic [LEN_W-1:0]  m_awlen;
    logic [2:0]        m_awsize;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic [1:0]        m_bresp;
    logic [7:0]        outstanding;

    cl_ddr_wr_arb #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .pipe_rst_n(pipe_rst_n),
        .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]), .s0_awid(s_awid[0]), .s0_awaddr(s_awaddr[0]),
        .s0_awlen(s_awlen[0]), .s0_awsize(s_awsize[0]), .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]),
        .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wlast(s_wlast[0]), .s0_bvalid(s_bvalid[0]),
        .s0_bready(s_bready[0]), .s0_bid(s_bid[0]), .s0_bresp(s_bresp[0]),
        .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]), .s1_awid(s_awid[1]), .s1_awaddr(s_awaddr[1]),
        .s1_awlen(s_awlen[1]), .s1_awsize(s_awsize[1]), .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]),
        .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wlast(s_wlast[1]), .s1_bvalid(s_bvalid[1]),
        .s1_bready(s_bready[1]), .s1_bid(s_bid[1]), .s1_bresp(s_bresp[1]),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_bvalid(m_bvalid),
        .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp), .outstanding(outstanding)
    );

    // ---------------- reference model state ----------------
    aw_t             aw_q[2][$];    // bursts waiting for their AW grant
    beat_t           w_q[2][$];     // beats still to be driven by each requester
    beat_t           ref_w[2][$];   // beats expected on the DDR side, per requester
    logic [ID_W-1:0] b_q[$];        // tagged IDs whose B the DDR model still owes
    int              cnt, cur, last_win, beats, cyc, last_mb_cyc, last_gnt_cyc, b_budget;
    bit              busy, aw_pend, in_data, b_act, simul_seen, wr_toggle;
    aw_t             exp_aw;
    logic [1:0]      cur_bresp;
    int              grant_seq[$];
    int              p_awv, p_wv, p_bready, p_awready, p_wready, p_bvalid;
    int              n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit rnd(input int p);
        return $urandom_range(99) < p;
    endfunction

    function automatic bit drained();
        return aw_q[0].size() == 0 && aw_q[1].size() == 0 && w_q[0].size() == 0 &&
               w_q[1].size() == 0 && !busy && b_q.size() == 0 && !b_act && cnt == 0;
    endfunction

    task automatic knobs(input int p);
        p_awv = p; p_wv = p; p_bready = p; p_awready = p; p_wready = p; p_bvalid = p;
    endtask

    task automatic add_burst(input int r, input logic [ID_W-2:0] id, input int len);
        aw_t a;
        beat_t b;
        a.id = id; a.addr = ADDR_W'($urandom); a.len = LEN_W'(len); a.size = 3'($urandom_range(7));
        aw_q[r].push_back(a);
        for (int i = 0; i <= len; i++) begin
            b.data = {$urandom, $urandom}; b.strb = STRB_W'($urandom); b.last = (i == len);
            w_q[r].push_back(b);
            ref_w[r].push_back(b);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            aw_q[r].delete(); w_q[r].delete(); ref_w[r].delete();
            s_awvalid[r] = 0; s_awid[r] = 0; s_awaddr[r] = 0; s_awlen[r] = 0; s_awsize[r] = 0;
            s_wvalid[r] = 0; s_wdata[r] = 0; s_wstrb[r] = 0; s_wlast[r] = 0; s_bready[r] = 0;
        end
        b_q.delete();
        cnt = 0; busy = 0; aw_pend = 0; in_data = 0; b_act = 0; last_win = 1; beats = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bid = 0; m_bresp = 0;
    endtask

    // Drive all bench-owned inputs for the coming cycle
    task automatic drive();
        for (int r = 0; r < 2; r++) begin
            s_awvalid[r] = aw_q[r].size() > 0 && rnd(p_awv);
            if (aw_q[r].size() > 0) begin
                s_awid[r] = aw_q[r][0].id; s_awaddr[r] = aw_q[r][0].addr;
                s_awlen[r] = aw_q[r][0].len; s_awsize[r] = aw_q[r][0].size;
            end
            s_wvalid[r] = w_q[r].size() > 0 && rnd(p_wv);
            if (w_q[r].size() > 0) begin
                s_wdata[r] = w_q[r][0].data; s_wstrb[r] = w_q[r][0].strb; s_wlast[r] = w_q[r][0].last;
            end
            s_bready[r] = rnd(p_bready);
        end
        m_awready = rnd(p_awready);
        m_wready  = wr_toggle ? !m_wready : rnd(p_wready);
        if (!b_act && b_q.size() > 0 && b_budget != 0 && rnd(p_bvalid)) begin
            b_act = 1; m_bid = b_q[0]; cur_bresp = 2'($urandom_range(3)); m_bresp = cur_bresp;
        end
        m_bvalid = b_act;
    endtask

    // Compare DUT against the model mid-cycle, then retire the handshakes of the coming edge
    task automatic monitor();
        bit aw[2], sw[2];
        bit maw, mw, mb, exp_g, both;
        int win, tgt;
        beat_t bt;
        cyc++;
        chk("outstanding", outstanding, cnt);
        both  = s_awvalid[0] && s_awvalid[1];
        exp_g = !busy && (s_awvalid[0] || s_awvalid[1]) && cnt < MAX_OUT;
        win   = both ? 1 - last_win : (s_awvalid[0] ? 0 : 1);
        chk("awready0", s_awready[0], exp_g && win == 0);
        chk("awready1", s_awready[1], exp_g && win == 1);
        chk("m_awvalid", m_awvalid, aw_pend);
        if (aw_pend) begin
            chk("m_awid", m_awid, {1'(cur), exp_aw.id});
            chk("m_awaddr", m_awaddr, exp_aw.addr);
            chk("m_awlen", m_awlen, exp_aw.len);
            chk("m_awsize", m_awsize, exp_aw.size);
        end
        chk("m_wvalid", m_wvalid, in_data && s_wvalid[cur]);
        chk("wready0", s_wready[0], in_data && cur == 0 && m_wready);
        chk("wready1", s_wready[1], in_data && cur == 1 && m_wready);
        mw = m_wvalid && m_wready;
        bt.last = 0;
        if (mw) begin
            if (ref_w[cur].size() == 0) chk("w_extra_beat", 1, 0);
            else begin
                bt = ref_w[cur].pop_front();
                chk("m_wdata", m_wdata, bt.data);
                chk("m_wstrb", m_wstrb, bt.strb);
                chk("m_wlast", m_wlast, bt.last);
            end
        end
        if (m_bvalid) begin
            tgt = int'(b_q[0][ID_W-1]);
            chk("bvalid_tgt", s_bvalid[tgt], 1);
            chk("bvalid_other", s_bvalid[1-tgt], 0);
            chk("bid", s_bid[tgt], b_q[0][ID_W-2:0]);
            chk("bresp", s_bresp[tgt], cur_bresp);
            chk("m_bready", m_bready, s_bready[tgt]);
        end else begin
            chk("bvalid_idle", s_bvalid[0] | s_bvalid[1], 0);
        end

        for (int r = 0; r < 2; r++) begin
            aw[r] = s_awvalid[r] && s_awready[r];
            sw[r] = s_wvalid[r] && s_wready[r];
            if (sw[r]) void'(w_q[r].pop_front());
        end
        maw = m_awvalid && m_awready;
        mb  = m_bvalid && m_bready;
        if (maw) begin
            aw_pend = 0; in_data = 1; beats = 0;
            if (mb) simul_seen = 1;
        end
        if (mw) begin
            beats++;
            if (bt.last) begin
                in_data = 0; busy = 0;
                b_q.push_back({1'(cur), exp_aw.id});
            end
        end
        if (mb) begin
            void'(b_q.pop_front());
            b_act = 0;
            if (b_budget > 0) b_budget--;
            last_mb_cyc = cyc;
        end
        cnt = cnt + int'(maw) - int'(mb);
        for (int r = 0; r < 2; r++) begin
            if (aw[r]) begin
                exp_aw = aw_q[r].pop_front();
                cur = r; aw_pend = 1; busy = 1; last_win = r;
                grant_seq.push_back(r);
                last_gnt_cyc = cyc;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic drain(input string tag, input int max);
        for (int i = 0; i < max && !drained(); i++) cycle();
        chk(tag, drained(), 1);
    endtask

    initial begin
        int first;
        model_reset();
        knobs(100);
        b_budget = -1; wr_toggle = 0; cyc = 0; simul_seen = 0; cur = 0; cur_bresp = 0;

        // reset values
        #2;
        chk("rst_outstanding", outstanding, 0);
        chk("rst_m_awvalid", m_awvalid, 0);
        chk("rst_m_awid", m_awid, 0);
        chk("rst_m_awaddr", m_awaddr, 0);
        chk("rst_m_wvalid", m_wvalid, 0);
        chk("rst_awready", s_awready[0] | s_awready[1], 0);
        chk("rst_wready", s_wready[0] | s_wready[1], 0);
        repeat (2) @(negedge clk);
        pipe_rst_n = 1;

        // single burst from requester 0
        add_burst(0, 7'd5, 3);
        drain("single_drain", 100);
        chk("single_grants", grant_seq.size(), 1);

        // contention: both valid all the time, grants must alternate
        grant_seq.delete();
        first = 1 - last_win;
        for (int i = 0; i < 8; i++) begin
            add_burst(0, 7'($urandom), $urandom_range(3));
            add_burst(1, 7'($urandom), $urandom_range(3));
        end
        drain("contention_drain", 2000);
        chk("contention_grants", grant_seq.size(), 16);
        for (int i = 0; i < grant_seq.size(); i++) chk("rr_order", grant_seq[i], (first + i) % 2);

        // backpressure: AW stalled 12 cycles, then W ready toggling
        p_awready = 0;
        add_burst(1, 7'h2a, 5);
        repeat (12) cycle();
        chk("bp_awvalid_held", m_awvalid, 1);
        p_awready = 100; wr_toggle = 1;
        drain("bp_drain", 200);
        wr_toggle = 0;

        // credit limit: B withheld, third AW waits for one B
        b_budget = 0;
        add_burst(0, 7'd1, 1); add_burst(1, 7'd2, 1); add_burst(0, 7'd3, 1);
        for (int i = 0; i < 60 && !(cnt == 2 && !busy); i++) cycle();
        repeat (5) cycle();
        chk("credit_blocked", aw_q[0].size() + aw_q[1].size(), 1);
        chk("credit_full", outstanding, 2);
        b_budget = 1;
        for (int i = 0; i < 20 && b_budget != 0; i++) cycle();
        cycle();
        chk("credit_next_cycle", last_gnt_cyc - last_mb_cyc, 1);
        b_budget = -1;
        drain("credit_drain", 200);

        // same-cycle AW accept and B return at outstanding == 1, B for requester 1
        b_budget = 0;
        add_burst(1, 7'd3, 0);
        for (int i = 0; i < 50 && !(cnt == 1 && !busy && b_q.size() == 1); i++) cycle();
        p_awready = 0;
        add_burst(0, 7'd9, 0);
        for (int i = 0; i < 20 && !aw_pend; i++) cycle();
        p_awready = 100; b_budget = 1;
        cycle();
        chk("simul_seen", simul_seen, 1);
        cycle();
        chk("simul_outstanding", outstanding, 1);
        b_budget = -1;
        drain("simul_drain", 200);

        // randomised traffic
        for (int blk = 0; blk < 10; blk++) begin
            p_awv = $urandom_range(30, 100); p_wv = $urandom_range(30, 100);
            p_bready = $urandom_range(30, 100); p_awready = $urandom_range(30, 100);
            p_wready = $urandom_range(30, 100); p_bvalid = $urandom_range(30, 100);
            for (int i = 0; i < 20; i++) add_burst($urandom_range(1), 7'($urandom), $urandom_range(7));
            drain("random_drain", 5000);
        end

        // reset in the middle of an 8-beat burst
        knobs(100);
        add_burst(0, 7'h11, 7);
        for (int i = 0; i < 40 && !(in_data && beats == 2); i++) cycle();
        chk("rst_mid_reached", in_data && beats == 2, 1);
        @(posedge clk);
        #1;
        pipe_rst_n = 0;
        #1;
        chk("rst_mid_outstanding", outstanding, 0);
        chk("rst_mid_m_awvalid", m_awvalid, 0);
        chk("rst_mid_m_wvalid", m_wvalid, 0);
        chk("rst_mid_wready", s_wready[0] | s_wready[1], 0);
        chk("rst_mid_m_awid", m_awid, 0);
        model_reset();
        repeat (2) @(negedge clk);
        pipe_rst_n = 1;
        knobs(100);
        add_burst(1, 7'h22, 2);
        drain("post_rst_drain", 100);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
